// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Patterns are active-low, bit6..bit0 = g,f,e,d,c,b,a.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_TRACK,
    ST_HOLD
  } seg7_state_t;

  // Stability counter only has to reach STABLE_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles <= 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/seg7_lookup.sv
// Inverse seven-segment map: pattern -> {legal digit, blank, digit value}.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_legal,
  output logic       o_blank,
  output logic [3:0] o_digit
);

  always_comb begin
    o_legal = 1'b1;
    o_blank = 1'b0;
    o_digit = 4'd0;
    case (i_pat)
      SEG_0:     o_digit = 4'd0;
      SEG_1:     o_digit = 4'd1;
      SEG_2:     o_digit = 4'd2;
      SEG_3:     o_digit = 4'd3;
      SEG_4:     o_digit = 4'd4;
      SEG_5:     o_digit = 4'd5;
      SEG_6:     o_digit = 4'd6;
      SEG_7:     o_digit = 4'd7;
      SEG_8:     o_digit = 4'd8;
      SEG_9:     o_digit = 4'd9;
      SEG_BLANK: begin
        o_legal = 1'b0;
        o_blank = 1'b1;
      end
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus reader: registers the bus, waits for a stable pattern,
// then commits it as a digit, blank or illegal pattern with error tracking.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       err_clr,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       locked,
  output logic       err_pulse,
  output logic       err_flag,
  output logic [3:0] err_cnt
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [6:0]    r_seg_q;
  logic [6:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [6:0]    r_committed;
  seg7_state_t   r_state;
  seg7_state_t   w_state_next;

  logic [3:0] r_digit;
  logic       r_digit_valid;
  logic       r_blank;
  logic       r_locked;
  logic       r_err_pulse;
  logic       r_err_flag;
  logic [3:0] r_err_cnt;

  logic       w_legal;
  logic       w_is_blank;
  logic [3:0] w_digit;
  logic       w_stable;
  logic       w_commit;
  logic       w_illegal_commit;
  logic [3:0] w_err_base;

  seg7_lookup u_lookup (
    .i_pat   (r_cand),
    .o_legal (w_legal),
    .o_blank (w_is_blank),
    .o_digit (w_digit)
  );

  assign w_stable = (r_cnt == CNT_MAX) && (r_seg_q == r_cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q <= SEG_BLANK;
      r_cand  <= SEG_BLANK;
      r_cnt   <= '0;
      r_state <= ST_EMPTY;
    end else begin
      r_seg_q <= seg_in;
      if (r_seg_q != r_cand) begin
        r_cand <= r_seg_q;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_state <= w_state_next;
    end
  end

  // A candidate equal to the committed pattern never commits, so a glitch
  // that settles back onto the held value stays silent.
  always_comb begin
    w_state_next = r_state;
    w_commit     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_stable) begin
          w_commit     = 1'b1;
          w_state_next = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (r_cand == r_committed) begin
          w_state_next = ST_HOLD;
        end else if (w_stable) begin
          w_commit     = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_cand != r_committed) w_state_next = ST_TRACK;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  assign w_illegal_commit = w_commit && !w_legal && !w_is_blank;
  // Clear is applied before a same-cycle illegal commit is counted.
  assign w_err_base = err_clr ? '0 : r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_committed   <= SEG_BLANK;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b0;
      r_locked      <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_flag    <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_digit_valid <= w_commit && w_legal;
      r_err_pulse   <= w_illegal_commit;
      r_err_flag    <= (r_err_flag && !err_clr) || w_illegal_commit;
      if (w_illegal_commit) begin
        r_err_cnt <= (w_err_base == 4'hF) ? w_err_base : w_err_base + 4'd1;
      end else begin
        r_err_cnt <= w_err_base;
      end
      if (w_commit) begin
        r_committed <= r_cand;
        r_locked    <= 1'b1;
        if (w_legal) begin
          r_digit <= w_digit;
          r_blank <= 1'b0;
        end else if (w_is_blank) begin
          r_blank <= 1'b1;
        end
      end
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign blank       = r_blank;
  assign locked      = r_locked;
  assign err_pulse   = r_err_pulse;
  assign err_flag    = r_err_flag;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: stimulus queues expected pulses,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_seg7_capture;

  logic       clk;
  logic       rst;
  logic [6:0] seg_in;
  logic       err_clr;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       locked;
  logic       err_pulse;
  logic       err_flag;
  logic [3:0] err_cnt;

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .err_clr     (err_clr),
    .digit       (digit),
    .digit_valid (digit_valid),
    .blank       (blank),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_flag    (err_flag),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    bit         is_err;
    logic [3:0] dig;
    logic       blk;
    logic       flag;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [6:0] P2   = 7'b0100100;
  localparam logic [6:0] P3   = 7'b0110000;
  localparam logic [6:0] P7   = 7'b1111000;
  localparam logic [6:0] P9   = 7'b0011000;
  localparam logic [6:0] PBLK = 7'b1111111;
  localparam logic [6:0] BADA = 7'b0101010;
  localparam logic [6:0] BADB = 7'b1010101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit is_err, input logic [3:0] d, input logic b,
                          input logic f, input logic [3:0] c);
    exp_t e;
    e.is_err = is_err;
    e.dig    = d;
    e.blk    = b;
    e.flag   = f;
    e.cnt    = c;
    q.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digit"},  {28'd0, digit}, 32'd0);
    chk({tag, "_dvalid"}, {31'd0, digit_valid}, 32'd0);
    chk({tag, "_blank"},  {31'd0, blank}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_epulse"}, {31'd0, err_pulse}, 32'd0);
    chk({tag, "_eflag"},  {31'd0, err_flag}, 32'd0);
    chk({tag, "_ecnt"},   {28'd0, err_cnt}, 32'd0);
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (digit_valid === 1'b1 || err_pulse === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_pulse", {30'd0, err_pulse, digit_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {30'd0, err_pulse, digit_valid},
              e.is_err ? 32'd2 : 32'd1);
          chk("pulse_digit", {28'd0, digit}, {28'd0, e.dig});
          chk("pulse_blank", {31'd0, blank}, {31'd0, e.blk});
          chk("pulse_eflag", {31'd0, err_flag}, {31'd0, e.flag});
          chk("pulse_ecnt",  {28'd0, err_cnt}, {28'd0, e.cnt});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_cnt;
    rst     = 1'b1;
    seg_in  = P2;
    err_clr = 1'b0;
    cyc(3);
    chk_reset_vals("rst");

    // First commit lands on the 6th edge after reset release.
    push_exp(1'b0, 4'd2, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    cyc(5);
    chk("early_dvalid", {31'd0, digit_valid}, 32'd0);
    chk("early_locked", {31'd0, locked}, 32'd0);
    cyc(1);
    chk("lat_dvalid", {31'd0, digit_valid}, 32'd1);
    chk("lat_digit",  {28'd0, digit}, 32'd2);
    chk("lat_locked", {31'd0, locked}, 32'd1);
    chk("lat_blank",  {31'd0, blank}, 32'd0);
    cyc(20);

    // Short glitch to 3 and back: no commit.
    seg_in = P3;
    cyc(3);
    seg_in = P2;
    cyc(10);
    chk("glitch_digit", {28'd0, digit}, 32'd2);

    push_exp(1'b0, 4'd3, 1'b0, 1'b0, 4'd0);
    seg_in = P3;
    cyc(10);
    chk("d3_digit", {28'd0, digit}, 32'd3);

    // Illegal pattern held long: exactly one error.
    push_exp(1'b1, 4'd3, 1'b0, 1'b1, 4'd1);
    seg_in = BADA;
    cyc(26);
    chk("bad_ecnt",  {28'd0, err_cnt}, 32'd1);
    chk("bad_eflag", {31'd0, err_flag}, 32'd1);
    chk("bad_digit", {28'd0, digit}, 32'd3);

    seg_in = PBLK;
    cyc(10);
    chk("blk_blank", {31'd0, blank}, 32'd1);
    chk("blk_digit", {28'd0, digit}, 32'd3);

    push_exp(1'b0, 4'd7, 1'b0, 1'b1, 4'd1);
    seg_in = P7;
    cyc(10);
    chk("d7_digit", {28'd0, digit}, 32'd7);
    chk("d7_blank", {31'd0, blank}, 32'd0);

    // Error counter saturation.
    exp_cnt = 4'd1;
    for (int i = 0; i < 17; i++) begin
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      push_exp(1'b1, 4'd7, 1'b0, 1'b1, exp_cnt);
      seg_in = (i % 2 == 0) ? BADA : BADB;
      cyc(8);
    end
    chk("sat_ecnt", {28'd0, err_cnt}, 32'd15);

    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("clr_eflag", {31'd0, err_flag}, 32'd0);
    chk("clr_ecnt",  {28'd0, err_cnt}, 32'd0);

    // err_clr coincident with the commit edge.
    push_exp(1'b1, 4'd7, 1'b0, 1'b1, 4'd1);
    seg_in = BADB;
    cyc(5);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("coinc_eflag", {31'd0, err_flag}, 32'd1);
    chk("coinc_ecnt",  {28'd0, err_cnt}, 32'd1);
    cyc(4);

    // Reset while tracking toward 9 aborts the commit.
    seg_in = P9;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk_reset_vals("abort");
    cyc(9);
    chk("abort_hold_dvalid", {31'd0, digit_valid}, 32'd0);
    chk("pending_expect", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
